// File: rtl/median_pkg.sv
// median_pkg: shared constants, types and compare rule for the streaming median filter
package median_pkg;
  localparam int MAX_WIN = 15;
  typedef logic [3:0] age_t;
  function automatic int idx_w(input int win);
    return $clog2(win);
  endfunction
  function automatic logic cmp_gt(input logic [32:0] a, input logic [32:0] b, input logic signed_mode);
    return signed_mode ? ($signed(a) > $signed(b)) : (a > b);
  endfunction
endpackage

// File: rtl/median_sort_window.sv
// median_sort_window: sorted window of WIN samples with age tags; one insert (and oldest evict) per ld
//   clk, rst_n : clock, async active-low reset
//   ld         : accept d this edge
//   fill       : valid entries before this insert (already forced to 0 on a flush)
//   d          : new sample
//   mid        : sorted slot WIN/2
//   lo, hi     : sorted slots 0 and WIN-1 (only with MEDIAN_MINMAX_EN)
module median_sort_window
  import median_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int WIN    = 3,
  parameter int SIGNED = 0
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      ld,
  input  logic [idx_w(WIN+1)-1:0]   fill,
  input  logic [DATA_W-1:0]         d,
  output logic [DATA_W-1:0]         mid
`ifdef MEDIAN_MINMAX_EN
  ,
  output logic [DATA_W-1:0]         lo,
  output logic [DATA_W-1:0]         hi
`endif
);
  localparam int FW = idx_w(WIN+1);
  logic [DATA_W-1:0] s  [WIN];
  logic [DATA_W-1:0] ns [WIN];
  age_t              a  [WIN];
  age_t              na [WIN];
  logic [WIN-1:0]    evict, le;
  logic [FW-1:0]     e, p;
  logic              full;
  function automatic logic [32:0] ext(input logic [DATA_W-1:0] v);
    return {{(33-DATA_W){SIGNED != 0 && v[DATA_W-1]}}, v};
  endfunction
  // e: slot being evicted (WIN when nothing leaves); p: insert position = kept entries <= d,
  // which lands the new sample above any equal entries
  always_comb begin
    full  = fill == FW'(WIN);
    e     = FW'(WIN);
    p     = '0;
    evict = '0;
    le    = '0;
    for (int j = 0; j < WIN; j++) begin
      evict[j] = full && a[j] == age_t'(WIN - 1);
      le[j]    = FW'(j) < fill && !evict[j] && !cmp_gt(ext(s[j]), ext(d), SIGNED != 0);
      if (evict[j]) e = FW'(j);
      p = p + FW'(le[j]);
    end
  end
  // each slot takes the compacted (evicted-removed) array shifted up by one above p
  for (genvar i = 0; i < WIN; i++) begin : g_slot
    localparam int UP = (i == WIN - 1) ? i : i + 1;
    localparam int DN = (i == 0) ? 0 : i - 1;
    assign ns[i] = FW'(i) < p  ? (FW'(i) < e ? s[i] : s[UP]) :
                   FW'(i) == p ? d : (FW'(DN) < e ? s[DN] : s[i]);
    assign na[i] = FW'(i) < p  ? (FW'(i) < e ? a[i] : a[UP]) + age_t'(1) :
                   FW'(i) == p ? age_t'(0) : (FW'(DN) < e ? a[DN] : a[i]) + age_t'(1);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)
      for (int i = 0; i < WIN; i++) begin
        s[i] <= '0;
        a[i] <= '0;
      end
    else if (ld)
      for (int i = 0; i < WIN; i++) begin
        s[i] <= ns[i];
        a[i] <= na[i];
      end
  assign mid = s[WIN/2];
`ifdef MEDIAN_MINMAX_EN
  assign lo = s[0];
  assign hi = s[WIN-1];
`endif
endmodule

// File: rtl/median_filter_stream.sv
// median_filter_stream: streaming sliding-window median, one sample per cycle, median one cycle later
//   clk, rst_n : clock, async active-low reset
//   en_i, d_i  : sample valid / sample
//   clr_i      : synchronous window flush (a same-cycle sample becomes the first entry)
//   done_o     : one-cycle pulse, median_o valid
//   median_o   : window median
//   fill_o     : valid window entries 0..WIN
//   min_o/max_o: window extremes, only when MEDIAN_MINMAX_EN is defined
module median_filter_stream
  import median_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int WIN    = 3,
  parameter int SIGNED = 0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en_i,
  input  logic                    clr_i,
  input  logic [DATA_W-1:0]       d_i,
  output logic                    done_o,
  output logic [DATA_W-1:0]       median_o,
  output logic [idx_w(WIN+1)-1:0] fill_o
`ifdef MEDIAN_MINMAX_EN
  ,
  output logic [DATA_W-1:0]       min_o,
  output logic [DATA_W-1:0]       max_o
`endif
);
  localparam int FW = idx_w(WIN+1);
  if (WIN % 2 == 0 || WIN < 3 || WIN > MAX_WIN) begin : g_bad_win
    $fatal(1, "median_filter_stream: WIN must be odd and within 3..15");
  end
  logic [FW-1:0]     fill_eff, fill_n;
  logic              pend, pend_n;
  logic [DATA_W-1:0] mid;
`ifdef MEDIAN_MINMAX_EN
  logic [DATA_W-1:0] lo, hi;
`endif
  always_comb begin
    fill_eff = clr_i ? '0 : fill_o;
    pend_n   = en_i && fill_eff >= FW'(WIN - 1);
    fill_n   = !en_i ? fill_eff : fill_eff == FW'(WIN) ? fill_eff : fill_eff + FW'(1);
  end
  median_sort_window #(.DATA_W(DATA_W), .WIN(WIN), .SIGNED(SIGNED)) u_win (
    .clk  (clk),
    .rst_n(rst_n),
    .ld   (en_i),
    .fill (fill_eff),
    .d    (d_i),
    .mid  (mid)
`ifdef MEDIAN_MINMAX_EN
    ,
    .lo   (lo),
    .hi   (hi)
`endif
  );
  // pend marks a full-window insert; the next edge publishes from the updated array unless flushed
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      fill_o   <= '0;
      pend     <= 1'b0;
      done_o   <= 1'b0;
      median_o <= '0;
    end else begin
      fill_o <= fill_n;
      pend   <= pend_n;
      done_o <= pend && !clr_i;
      if (pend && !clr_i) median_o <= mid;
    end
`ifdef MEDIAN_MINMAX_EN
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      min_o <= '0;
      max_o <= '0;
    end else if (pend && !clr_i) begin
      min_o <= lo;
      max_o <= hi;
    end
`endif
endmodule
